vip_sdram_scheduler: RTL
========================

# vip_sdram_scheduler

Frame-buffer scheduler for the PAL video-in-pipe datapath: shares the single SDRAM command port between the BT656 capture write FIFO, the VGA display read FIFO and periodic auto-refresh. Issues one fixed-length burst command at a time to the SDRAM command controller and generates burst addresses. Manages three frame buffers (triple buffering) so capture and display run on independent frame timing without tearing. Sits in `clk_sys` domain between the capture/display FIFOs and the SDRAM controller.

## Interface
- `BURST_LEN`, 256: words per burst (power of two).
- `FRAME_WORDS`, 414720: 16-bit words per frame (720×576 YCbCr 4:2:2); multiple of `BURST_LEN`.
- `FRAME_STRIDE_LOG2`, 19: buffer base = index << 19.
- `ADDR_W`, 22: SDRAM word address width.
- `FIFO_DEPTH`, 1024: read FIFO depth in words.
- `LVL_W`, 11: FIFO level width.
- `WR_URGENT`, 768: write FIFO level at/above which write outranks read.
- `REFRESH_PERIOD`, 780: `clk_sys` cycles between refresh requests.
- `clk_sys  in  1`: system/SDRAM clock.
- `reset_n  in  1`: asynchronous, active-low reset.
- `wr_fifo_level  in  LVL_W`: words held in capture FIFO.
- `wr_frame_start  in  1`: one-cycle pulse, capture vsync (already synchronised).
- `rd_fifo_level  in  LVL_W`: words held in display FIFO.
- `rd_frame_start  in  1`: one-cycle pulse, display vsync.
- `cmd_valid  out  1`: command offered.
- `cmd_ready  in  1`: controller accepts command.
- `cmd_write  out  1`: 1 = write burst, 0 = read burst.
- `cmd_refresh  out  1`: 1 = auto-refresh (address ignored).
- `cmd_addr  out  ADDR_W`: burst start word address.
- `burst_done  in  1`: one-cycle pulse, accepted command finished.
- `wr_active  out  1`: capture FIFO steered to controller.
- `rd_active  out  1`: display FIFO steered from controller.
- `frame_drop  out  1`: one-cycle pulse, capture frame abandoned incomplete.

## Operation
- Buffers 0..2. Registers: `wr_buf`, `rd_buf`, `last_done` (2 bits each), `wr_offset`, `rd_offset` (word offsets, 0..`FRAME_WORDS`).
- Reset: `wr_buf`=0, `rd_buf`=1, `last_done`=1, both offsets = `FRAME_WORDS` (idle), FSM IDLE, refresh pending 0, timer 0; all outputs 0.
- `rd_frame_start`: `rd_buf`←`last_done`, `rd_offset`←0.
- `wr_frame_start`: if `wr_offset` ∉ {0, `FRAME_WORDS`} or final write burst in flight, pulse `frame_drop`. `wr_buf`← the one index ≠ `last_done` and ≠ next `rd_buf`; `wr_offset`←0; clear final-burst flag.
- Simultaneous starts: reader update takes effect first; writer choice excludes the new `rd_buf`.
- Needs: `rd_need` = `rd_offset`<`FRAME_WORDS` and `rd_fifo_level` ≤ `FIFO_DEPTH`−`BURST_LEN`. `wr_need` = `wr_offset`<`FRAME_WORDS` and `wr_fifo_level` ≥ `BURST_LEN`.
- Priority in IDLE: refresh pending > write if `wr_fifo_level` ≥ `WR_URGENT` > read > write.
- FSM IDLE → ISSUE on any winner; ISSUE holds `cmd_valid` and all `cmd_*` fields stable until `cmd_ready`; → BUSY on handshake; BUSY → IDLE on `burst_done`.
- On write/read handshake: offset += `BURST_LEN`. `cmd_addr` = {buf, offset} with the pre-increment offset, zero-extended to `ADDR_W`. Write reaching `FRAME_WORDS` sets final-burst flag. `burst_done` with flag set: `last_done`←`wr_buf`, flag cleared.
- `wr_active` / `rd_active` high from handshake to `burst_done` for the respective burst type; never both.
- Refresh timer counts 0..`REFRESH_PERIOD`−1 free-running; wrap sets pending; pending cleared on refresh handshake. Wrap while pending: stays set, no queueing.
- Frame start during BUSY: offsets and buffers update immediately; the in-flight burst completes unaffected.
- `burst_done` outside BUSY is ignored.

## Timing
- Need asserted in cycle N → `cmd_valid` high at N+1 (registered decision).
- `cmd_valid` never deasserts before `cmd_ready`.
- Minimum command spacing is handshake → `burst_done` → IDLE → ISSUE, so the next `cmd_valid` appears 2 cycles after `burst_done`.
- `frame_drop` is registered and appears 1 cycle after `wr_frame_start`.
- Async reset forces every output low immediately, mid-burst included; the SDRAM controller is reset in the same domain.

## Structure
- `vip_pkg`: FSM state enum (IDLE/ISSUE/BUSY), buffer index type, command-kind encoding, default frame constants.
- Sub-module `sdr_refresh_timer`: counter plus pending flag with clear input.

## Test plan
- Bench overrides `FRAME_WORDS`=1024. After reset, `wr_frame_start` then `wr_fifo_level`=256 held → four writes to addresses 0x000000, 0x000100, 0x000200, 0x000300 (buf 0); after the fourth `burst_done`, `last_done`=0.
- `rd_frame_start` after that completion, `rd_fifo_level`=0 → reads from 0x000000 upward; `rd_active` high only during read bursts.
- `wr_frame_start` while `wr_offset`=512 → `frame_drop` one pulse; `last_done` unchanged; new `wr_buf` ∉ {`rd_buf`, `last_done`}.
- Refresh pending, read need and write need (`wr_fifo_level`=256) all in the same cycle → refresh issued first, then read; repeat with `wr_fifo_level`=800 → refresh, then write.
- `cmd_ready` held low 10 cycles → `cmd_valid`, `cmd_addr`, `cmd_write` stable throughout; offset advances by 256 only on the handshake.
- `reset_n` low during BUSY → all outputs 0 asynchronously; after release, no command until a frame start or refresh wrap.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared types and defaults for the video-in-pipe SDRAM frame-buffer scheduler.
// Buffer selection helper for triple buffering lives here so every user agrees on it.
package vip_pkg;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_BUSY  = 2'd2;

   typedef logic [1:0] buf_idx_t;

   typedef enum logic [1:0] {
      CMD_NONE    = 2'd0,
      CMD_READ    = 2'd1,
      CMD_WRITE   = 2'd2,
      CMD_REFRESH = 2'd3
   } cmd_kind_t;

   localparam int DEF_BURST_LEN         = 256;
   localparam int DEF_FRAME_WORDS       = 414720;
   localparam int DEF_FRAME_STRIDE_LOG2 = 19;
   localparam int DEF_ADDR_W            = 22;
   localparam int DEF_FIFO_DEPTH        = 1024;
   localparam int DEF_LVL_W             = 11;
   localparam int DEF_WR_URGENT         = 768;
   localparam int DEF_REFRESH_PERIOD    = 780;

   // Lowest buffer index that is neither a nor b; with three buffers one always exists.
   function automatic buf_idx_t free_buf(input buf_idx_t a, input buf_idx_t b);
      buf_idx_t pick;
      pick = 2'd2;
      if (a != 2'd0 && b != 2'd0)
         pick = 2'd0;
      else if (a != 2'd1 && b != 2'd1)
         pick = 2'd1;
      return pick;
   endfunction

endpackage

// File: rtl/sdr_refresh_timer.sv
// Free-running refresh interval counter with a sticky request flag.
// A wrap while the flag is already set does not queue a second request.
module sdr_refresh_timer #(
   parameter int PERIOD = 780
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic clear,
   output logic pending
);

   localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;

   logic [CNT_W-1:0] count;
   logic             wrap;

   assign wrap = (count == CNT_W'(PERIOD - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         count   <= '0;
         pending <= 1'b0;
      end else begin
         count <= wrap ? '0 : count + CNT_W'(1);
         // A fresh interval expiring outranks the clear of the previous request.
         if (wrap)
            pending <= 1'b1;
         else if (clear)
            pending <= 1'b0;
      end
   end

endmodule

// File: rtl/vip_sdram_scheduler.sv
// Arbitrates the SDRAM command port between capture writes, display reads and refresh,
// and rotates three frame buffers so capture and display never touch the same frame.
module vip_sdram_scheduler
   import vip_pkg::*;
#(
   parameter int BURST_LEN         = DEF_BURST_LEN,
   parameter int FRAME_WORDS       = DEF_FRAME_WORDS,
   parameter int FRAME_STRIDE_LOG2 = DEF_FRAME_STRIDE_LOG2,
   parameter int ADDR_W            = DEF_ADDR_W,
   parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
   parameter int LVL_W             = DEF_LVL_W,
   parameter int WR_URGENT         = DEF_WR_URGENT,
   parameter int REFRESH_PERIOD    = DEF_REFRESH_PERIOD
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [LVL_W-1:0]  wr_fifo_level,
   input  logic              wr_frame_start,
   input  logic [LVL_W-1:0]  rd_fifo_level,
   input  logic              rd_frame_start,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_write,
   output logic              cmd_refresh,
   output logic [ADDR_W-1:0] cmd_addr,
   input  logic              burst_done,
   output logic              wr_active,
   output logic              rd_active,
   output logic              frame_drop
);

   localparam int OFF_W = $clog2(FRAME_WORDS + 1);
   localparam logic [OFF_W-1:0] FRAME_END  = OFF_W'(FRAME_WORDS);
   localparam logic [OFF_W-1:0] BURST_STEP = OFF_W'(BURST_LEN);
   localparam logic [LVL_W-1:0] RD_ROOM    = LVL_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [LVL_W-1:0] WR_FILL    = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0] WR_URG     = LVL_W'(WR_URGENT);

   state_t           state;
   buf_idx_t         wr_buf, rd_buf, last_done, rd_buf_next;
   logic [OFF_W-1:0] wr_offset, rd_offset;
   logic             final_burst, refresh_pending;
   logic             handshake, wr_handshake, rd_handshake;
   logic             rd_need, wr_need, start_hold;
   cmd_kind_t        winner;

   function automatic logic [ADDR_W-1:0] burst_addr(input buf_idx_t b, input logic [OFF_W-1:0] off);
      return (ADDR_W'(b) << FRAME_STRIDE_LOG2) | ADDR_W'(off);
   endfunction

   sdr_refresh_timer #(.PERIOD(REFRESH_PERIOD)) u_refresh (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clear   (handshake && cmd_refresh),
      .pending (refresh_pending)
   );

   assign handshake    = (state == ST_ISSUE) && cmd_ready;
   assign wr_handshake = handshake && cmd_write && !cmd_refresh;
   assign rd_handshake = handshake && !cmd_write && !cmd_refresh;
   assign rd_need      = (rd_offset < FRAME_END) && (rd_fifo_level <= RD_ROOM);
   assign wr_need      = (wr_offset < FRAME_END) && (wr_fifo_level >= WR_FILL);
   assign rd_buf_next  = rd_frame_start ? last_done : rd_buf;
   // Offsets are about to be rewritten; deciding now would address the old frame.
   assign start_hold   = wr_frame_start || rd_frame_start;

   // NOTE: default assignment first so no path leaves winner unassigned (no latch).
   always_comb begin
      winner = CMD_NONE;
      if (refresh_pending)
         winner = CMD_REFRESH;
      else if (wr_need && (wr_fifo_level >= WR_URG))
         winner = CMD_WRITE;
      else if (rd_need)
         winner = CMD_READ;
      else if (wr_need)
         winner = CMD_WRITE;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cmd_valid   <= 1'b0;
         cmd_write   <= 1'b0;
         cmd_refresh <= 1'b0;
         cmd_addr    <= '0;
         wr_active   <= 1'b0;
         rd_active   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (winner != CMD_NONE && !start_hold) begin
                  state       <= ST_ISSUE;
                  cmd_valid   <= 1'b1;
                  cmd_write   <= (winner == CMD_WRITE);
                  cmd_refresh <= (winner == CMD_REFRESH);
                  if (winner == CMD_WRITE)
                     cmd_addr <= burst_addr(wr_buf, wr_offset);
                  else if (winner == CMD_READ)
                     cmd_addr <= burst_addr(rd_buf, rd_offset);
                  else
                     cmd_addr <= '0;
               end
            end
            ST_ISSUE: begin
               if (cmd_ready) begin
                  state     <= ST_BUSY;
                  cmd_valid <= 1'b0;
                  wr_active <= cmd_write && !cmd_refresh;
                  rd_active <= !cmd_write && !cmd_refresh;
               end
            end
            ST_BUSY: begin
               if (burst_done) begin
                  state     <= ST_IDLE;
                  wr_active <= 1'b0;
                  rd_active <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Buffer rotation and frame progress; frame starts override burst bookkeeping.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_buf      <= 2'd0;
         rd_buf      <= 2'd1;
         last_done   <= 2'd1;
         wr_offset   <= FRAME_END;
         rd_offset   <= FRAME_END;
         final_burst <= 1'b0;
         frame_drop  <= 1'b0;
      end else begin
         frame_drop <= 1'b0;

         if (rd_frame_start) begin
            rd_buf    <= last_done;
            rd_offset <= '0;
         end else if (rd_handshake) begin
            rd_offset <= rd_offset + BURST_STEP;
         end

         if (wr_frame_start) begin
            frame_drop  <= ((wr_offset != '0) && (wr_offset != FRAME_END)) || final_burst;
            wr_buf      <= free_buf(last_done, rd_buf_next);
            wr_offset   <= '0;
            final_burst <= 1'b0;
         end else begin
            if (wr_handshake) begin
               wr_offset <= wr_offset + BURST_STEP;
               if (wr_offset + BURST_STEP == FRAME_END)
                  final_burst <= 1'b1;
            end
            if ((state == ST_BUSY) && burst_done && final_burst) begin
               last_done   <= wr_buf;
               final_burst <= 1'b0;
            end
         end
      end
   end

endmodule
